// File: rtl/mul_pkg.sv
// mul_pkg: op encodings, FSM states and iteration count shared by the
// iterative multiplier and the multicycle controller.
package mul_pkg;
    localparam logic [1:0] MUL_OP_MUL   = 2'b00;
    localparam logic [1:0] MUL_OP_UMULL = 2'b01;
    localparam logic [1:0] MUL_OP_SMULL = 2'b10;
    localparam int MUL_ITERS = 32;
    localparam int MUL_CNT_W = $clog2(MUL_ITERS);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mul_state_t;
endpackage

// File: rtl/mul_iter_unit_if.sv
// mul_iter_unit_if: request/result bundle between the controller (master)
// and the iterative multiplier (slave).
interface mul_iter_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    modport master (output start, op, a, b, input busy, done, lo, hi);
    modport slave  (input start, op, a, b, output busy, done, lo, hi);
endinterface

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: conditional two's complement, used for operand magnitudes
// and for negating the final product.
module mul_sign_fix #(parameter int WIDTH = 32) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);
    assign o_val = i_neg ? (~i_val + 1'b1) : i_val;
endmodule

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: fixed-latency radix-2 shift-add 32x32->64 multiplier.
// Define MUL_SIGNED_EN to implement SMULL; otherwise op=10 behaves as UMULL.
module mul_iter_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_iter_unit_if.slave bus
);
    mul_state_t             r_state;
    mul_state_t             w_state_nxt;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [WIDTH-1:0]       r_acc;
    logic [MUL_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]       r_lo;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_result;
    logic                   w_accept;
    logic                   w_last;

    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = r_cnt == MUL_CNT_W'(MUL_ITERS - 1);
    assign w_sum    = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_prod   = {r_acc, r_mplier};

`ifdef MUL_SIGNED_EN
    logic w_signed_op;
    logic r_neg;
    assign w_signed_op = bus.op == MUL_OP_SMULL;
    mul_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
        .i_neg(w_signed_op & bus.a[WIDTH-1]),
        .i_val(bus.a),
        .o_val(w_mag_a)
    );
    mul_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
        .i_neg(w_signed_op & bus.b[WIDTH-1]),
        .i_val(bus.b),
        .o_val(w_mag_b)
    );
    mul_sign_fix #(.WIDTH(2*WIDTH)) u_prod_fix (
        .i_neg(r_neg),
        .i_val(w_prod),
        .o_val(w_result)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_neg <= 1'b0;
        else if (w_accept)
            r_neg <= w_signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`else
    logic w_unused_op;
    assign w_unused_op = ^bus.op;
    assign w_mag_a     = bus.a;
    assign w_mag_b     = bus.b;
    assign w_result    = w_prod;
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
                      (r_state == RUN)  ? (w_last ? FIX : RUN) :
                      (r_state == FIX)  ? DONE : IDLE;
    end

    // Each RUN cycle adds into the upper half, then shifts {acc, mplier} right.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_acc    <= w_sum[WIDTH:1];
            r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
        end else if (r_state == FIX) begin
            r_lo     <= w_result[WIDTH-1:0];
            r_hi     <= w_result[2*WIDTH-1:WIDTH];
        end

    assign bus.busy = r_state != IDLE;
    assign bus.done = r_state == DONE;
    assign bus.lo   = r_lo;
    assign bus.hi   = r_hi;
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: directed vectors against a cycle-level behavioural model
// of the multiplier, plus hand-computed literal results.
module tb_mul_iter_unit;
    import mul_pkg::*;
    localparam int LAT = 34;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int m_age = 0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_prod = '0;

    mul_iter_unit_if #(.WIDTH(32)) bus();
    mul_iter_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] model_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
        if (op == MUL_OP_SMULL)
            return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`endif
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Model: age counts cycles since acceptance; result appears at age LAT.
    always @(posedge clk or negedge reset)
        if (!reset) begin
            m_age = 0;
            m_prod = '0;
        end else if (m_age == 0) begin
            if (bus.start) begin
                m_age = 1;
                m_pend = model_prod(bus.op, bus.a, bus.b);
            end
        end else if (m_age == LAT)
            m_age = 0;
        else begin
            m_age++;
            if (m_age == LAT) m_prod = m_pend;
        end

    always @(negedge clk)
        if (chk_en) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_age != 0));
            check("cyc_done", 64'(bus.done), 64'(m_age == LAT));
            check("cyc_lo", 64'(bus.lo), 64'(m_prod[31:0]));
            check("cyc_hi", 64'(bus.hi), 64'(m_prod[63:32]));
        end

    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input string tag);
        int cyc;
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tag, cyc);
        check({tag, "_lo"}, 64'(bus.lo), 64'(elo));
        check({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        @(negedge clk);
        check({tag, "_idle"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int cyc;
        int dones;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_lo", 64'(bus.lo), 64'(0));
        check("rst_hi", 64'(bus.hi), 64'(0));
        reset = 1'b1;
        chk_en = 1'b1;
        run_op(MUL_OP_MUL, 32'd7, 32'd6, 32'h0000002A, 32'h0, "mul_7x6");
        run_op(MUL_OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, "umull_max");
`ifdef MUL_SIGNED_EN
        run_op(MUL_OP_SMULL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, "smull_m1x2");
        run_op(MUL_OP_SMULL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'hFFFFFFFF, "smull_m3x5");
`else
        run_op(MUL_OP_SMULL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h00000001, "smull_m1x2");
        run_op(MUL_OP_SMULL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 32'h00000004, "smull_m3x5");
`endif
        run_op(MUL_OP_SMULL, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, "smull_min");
        run_op(2'b11, 32'h00010000, 32'h00030000, 32'h0, 32'h00000003, "op11");
        run_op(MUL_OP_UMULL, 32'h0, 32'h12345678, 32'h0, 32'h0, "zero");
        // start re-pulsed while busy must be ignored
        @(negedge clk);
        bus.op = MUL_OP_UMULL; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 11;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("repulse_latency", 64'(cyc), 64'(LAT));
        check("repulse_lo", 64'(bus.lo), 64'(15));
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("repulse_second_done", 64'(dones), 64'(0));
        // asynchronous reset mid-operation
        @(negedge clk);
        bus.a = 32'h1234; bus.b = 32'h10; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", 64'(bus.busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_done", 64'(bus.done), 64'(0));
        check("arst_lo", 64'(bus.lo), 64'(0));
        check("arst_hi", 64'(bus.hi), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        run_op(MUL_OP_UMULL, 32'd2, 32'd3, 32'd6, 32'd0, "post_rst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not reach the end, failures=%0d", failures);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mul_iter_unit.md
# mul_iter_unit

Iterative 32×32 multiplier serving the multicycle controller's multiply path. The controller pulses `start` while in its multiply-execute state and stalls there until `done`. It then writes `lo` and `hi` back over two register-file cycles (low word first, high word second). This block replaces a single-cycle combinational multiplier with a fixed-latency radix-2 shift-add datapath, freeing timing on the ALU path.

## Interface
Parameters:
- `WIDTH`, 32, operand width; the product is `2*WIDTH`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse, sampled only in IDLE.
- `op` in 2: operation select. `00` MUL (low word used), `01` UMULL, `10` SMULL, `11` treated as UMULL.
- `a` in WIDTH: multiplicand (Rn).
- `b` in WIDTH: multiplier (Rm).
- `busy` out 1: high from the cycle after start is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse; `lo` and `hi` are valid from this cycle onward.
- `lo` out WIDTH: product bits [WIDTH-1:0].
- `hi` out WIDTH: product bits [2*WIDTH-1:WIDTH].

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, with `start=1`:
  - latch the operand magnitudes and the sign flag `neg = signed_op & (a[31]^b[31])`.
  - clear the accumulator and set iteration count = 0.
  - go to RUN.
- IDLE, with `start=0`: stay in IDLE.
- RUN, each cycle:
  - if multiplier bit 0 is set, the upper accumulator half is incremented by the multiplicand, with carry into bit 64.
  - then shift the {accumulator, multiplier} pair right by 1.
  - increment the count.
  - after the 32nd iteration, go to FIX.
- FIX:
  - if `neg`, replace the 64-bit product with its two's complement; otherwise leave it unchanged.
  - load `lo` and `hi`.
  - go to DONE.
- DONE: assert `done` for one cycle, then return to IDLE.
- `lo` and `hi` hold their value until the next FIX. They are not cleared when a new start is accepted.
- `start` while `busy` is ignored: no restart and no queuing.
- MUL computes the full 64-bit product. `hi` is valid but the controller does not use it.
- Signed magnitude: `|0x80000000|` is `0x80000000` as an unsigned value; the result is correct.
- Fixed latency: there is no early termination for zero operands.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `lo=0`, `hi=0`, internal accumulator and counter 0.
- Cycle 0: `start` is sampled high in IDLE.
- Cycles 1–32: RUN, with `busy=1`.
- Cycle 33: FIX.
- Cycle 34: DONE, with `done=1`, `busy=1`, and `lo`/`hi` valid.
- Cycle 35: IDLE, with `busy=0`. A new `start` is accepted in this cycle.
- Start-to-done latency is 34 cycles. Back-to-back throughput is one product per 35 cycles.
- A `start` held high across DONE into IDLE launches a second operation. The controller's responsibility is to deassert `start` before leaving its execute state.
- Reset asserted mid-operation: the block returns to IDLE immediately, asynchronously. All outputs take their reset values and any partial product is discarded.

## Configuration
- `MUL_SIGNED_EN` defined:
  - SMULL is implemented: magnitude conversion of operands at start, and conditional negation in FIX.
- `MUL_SIGNED_EN` undefined:
  - `op=10` is treated as UMULL.
  - the magnitude and negation logic is absent.
  - `neg` is tied to 0, and FIX only loads the outputs.

## Structure
- Shared package `mul_pkg` contains:
  - the `op` encodings `MUL_OP_MUL`, `MUL_OP_UMULL`, `MUL_OP_SMULL`;
  - the state enum `mul_state_t`;
  - `MUL_ITERS = 32`.
- The controller imports the same op encodings.
- One sub-module, `mul_sign_fix`: a combinational `WIDTH`-parameterised conditional two's-complement. It is instanced for operand magnitude (at WIDTH) and product negation (at 2*WIDTH), and only under `MUL_SIGNED_EN`.

## Test plan
- MUL `a=7`, `b=6`, start at cycle 0 → `done` at cycle 34, `lo=0x0000002A`, `hi=0`, `busy` low at cycle 35.
- UMULL `a=0xFFFFFFFF`, `b=0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`.
- SMULL `a=0xFFFFFFFF` (−1), `b=2` → with `MUL_SIGNED_EN`: `hi=0xFFFFFFFF`, `lo=0xFFFFFFFE`. Without it: `hi=0x00000001`, `lo=0xFFFFFFFE`.
- SMULL `a=b=0x80000000` with `MUL_SIGNED_EN` → `hi=0x40000000`, `lo=0`.
- UMULL 3×5 started; `start` re-pulsed at cycle 10 with `a=b=9` → single `done` at cycle 34 with `lo=15`; no second `done`.
- `reset` driven low at cycle 20 of a UMULL → `busy`, `done`, `lo`, `hi` all 0 at once. After release, a fresh 2×3 yields `lo=6` 34 cycles after its start.
